exc_redirect: RTL and testbench
===============================

# exc_redirect

Exception/ERET redirect controller sitting directly downstream of the CP0 block in the dual-issue pipeline. Consumes CP0's per-lane exception (`cp0_intexp_1/2`) and clean (`cp0_cln_1/2`) strobes plus `EPC_o`. Sequences a pipeline flush followed by a fetch redirect, either to the exception vector or, for ERET, to EPC. Holds the PC stalled until the fetch stage accepts the new target.

## Interface
Parameters:
- `EXC_VECTOR`, default 32'hBFC0_0380: exception entry address.
- `FLUSH_CYCLES`, default 2: cycles `flush_pipe` is held. Legal range 1..15.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cp0_intexp_1`  in  1  lane-1 exception/interrupt taken.
- `cp0_intexp_2`  in  1  lane-2 exception/interrupt taken.
- `cp0_cln_1`  in  1  lane-1 clean request (exception or ERET).
- `cp0_cln_2`  in  1  lane-2 clean request.
- `epc_i`  in  32  CP0 `EPC_o`.
- `redirect_ready`  in  1  fetch accepts redirect this cycle.
- `mem2_clr`  out  1  combinational; kill lane-2 MEM result this cycle.
- `flush_pipe`  out  1  registered; clear IF/ID/EX/MEM of both lanes.
- `stall_pc`  out  1  registered; freeze PC update.
- `redirect_valid`  out  1  registered; redirect target valid.
- `redirect_pc`  out  32  registered; target address.
- `redirect_is_eret`  out  1  registered; current redirect is ERET.
- `exc_count`, `eret_count`  out  32 each  only when `EXC_REDIRECT_STAT_EN` is defined.

## Operation
- States:
  - IDLE: default state.
  - FLUSH: counter `fcnt` counts from 0 to `FLUSH_CYCLES-1`.
  - REDIRECT: hold the target until fetch accepts it.
- Event (evaluated in IDLE only): `ev = cp0_cln_1 | cp0_intexp_1 | cp0_cln_2 | cp0_intexp_2`.
- Winning lane:
  - Lane 1 wins if `cp0_cln_1 | cp0_intexp_1`; otherwise lane 2.
  - Kind is exception if the winner's `intexp` is set; otherwise ERET.
- `mem2_clr = (state==IDLE) & (cp0_cln_1 | cp0_intexp_1)`.
  - A lane-2 event with no lane-1 event leaves lane 1 committing.
- IDLE→FLUSH on `ev`:
  - latch kind into `redirect_is_eret`;
  - set `flush_pipe=1`, `stall_pc=1`, `fcnt=0`.
- FLUSH:
  - `fcnt` increments each cycle.
  - When `fcnt==FLUSH_CYCLES-1`, go to REDIRECT: `flush_pipe=0`, `redirect_valid=1`.
  - `redirect_pc` = `epc_i` sampled on that edge if ERET, else `EXC_VECTOR`.
  - Sampling late covers the one-cycle lag of `EPC_o` behind EPC.
- REDIRECT:
  - `redirect_valid`, `redirect_pc` and `stall_pc` are held stable while `redirect_ready=0`.
  - On `redirect_ready=1`, go to IDLE next edge: `redirect_valid=0`, `stall_pc=0`, `redirect_is_eret=0`.
- All CP0 strobes arriving while not in IDLE are ignored; those instructions are being flushed.

## Timing
- Reset values: all registered outputs 0, `redirect_pc` = 0, state IDLE, `fcnt` = 0, counters 0.
- Event at cycle T:
  - `flush_pipe` high T+1 … T+FLUSH_CYCLES;
  - `redirect_valid` high from T+FLUSH_CYCLES+1.
- Minimum event-to-IDLE: FLUSH_CYCLES+2 cycles when `redirect_ready` is already high.
- `redirect_ready` high during IDLE or FLUSH has no effect.
- Back-to-back events: an event sampled in the same cycle IDLE is re-entered is accepted.
  - No dead cycle: IDLE lasts ≥1 cycle, and the event is taken in it.
- Simultaneous lane-1 and lane-2 events: lane 1 wins and `mem2_clr=1`.
- Reset asserted in any state: next edge returns to IDLE with reset values. An in-flight redirect is dropped.
- `fcnt` is 4 bits; no wrap because it is bounded by FLUSH_CYCLES ≤ 15.

## Configuration
- `EXC_REDIRECT_STAT_EN` defined:
  - `exc_count` increments on each accepted exception event (IDLE→FLUSH, kind exception);
  - `eret_count` increments on each accepted ERET event;
  - both wrap modulo 2^32 and clear on reset.
- `EXC_REDIRECT_STAT_EN` undefined: both ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Lane-1 exception:
  - stimulus: `cp0_intexp_1=cp0_cln_1=1` for one cycle at T, FLUSH_CYCLES=2, `redirect_ready=1`;
  - response: `mem2_clr=1` at T, `flush_pipe` at T+1..T+2, `redirect_valid=1` with `redirect_pc=0xBFC00380` at T+3, IDLE at T+4.
- Lane-2 ERET:
  - stimulus: `cp0_cln_2=1`, `cp0_intexp_2=0`; `epc_i` changes from 0x0 to 0x80001234 at T+1;
  - response: `mem2_clr=0`, `redirect_pc=0x80001234`, `redirect_is_eret=1`.
- Simultaneous events:
  - stimulus: lane-1 ERET and lane-2 exception in the same cycle;
  - response: ERET wins, `mem2_clr=1`, `eret_count` (if enabled) becomes 1 and `exc_count` stays 0.
- Backpressure and ignored strobes:
  - stimulus: `redirect_ready=0` for 5 cycles in REDIRECT, with `cp0_intexp_1` pulsed meanwhile;
  - response: outputs hold stable, the pulse is ignored, exactly one redirect completes.
- Reset mid-FLUSH:
  - stimulus: `reset=1` at T+1;
  - response: at T+2 all outputs 0 and state IDLE; no redirect ever issued.

Source files
------------

// File: rtl/exc_redirect.sv
// exc_redirect: exception / ERET redirect sequencer downstream of CP0.
// Flushes both lanes for FLUSH_CYCLES cycles, then presents the redirect
// target (exception vector or EPC) until fetch accepts it, keeping the PC
// stalled throughout. Define EXC_REDIRECT_STAT_EN to add the exc_count /
// eret_count statistics ports.
module exc_redirect #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int          FLUSH_CYCLES = 2   // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cp0_intexp_1,
    input  logic        cp0_intexp_2,
    input  logic        cp0_cln_1,
    input  logic        cp0_cln_2,
    input  logic [31:0] epc_i,
    input  logic        redirect_ready,
    output logic        mem2_clr,
    output logic        flush_pipe,
    output logic        stall_pc,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        redirect_is_eret
`ifdef EXC_REDIRECT_STAT_EN
    ,
    output logic [31:0] exc_count,
    output logic [31:0] eret_count
`endif
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FLUSH    = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    localparam logic [3:0] FCNT_LAST = 4'(FLUSH_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_fcnt;
    logic        r_flush;
    logic        r_stall;
    logic        r_valid;
    logic [31:0] r_pc;
    logic        r_is_eret;

    logic        w_idle;
    logic        w_lane1;
    logic        w_lane2;
    logic        w_ev;
    logic        w_is_exc;
    logic        w_accept;

    // Event decode: lane 1 has priority; kind comes from the winning lane.
    assign w_idle   = (r_state == S_IDLE);
    assign w_lane1  = cp0_cln_1 | cp0_intexp_1;
    assign w_lane2  = cp0_cln_2 | cp0_intexp_2;
    assign w_ev     = w_lane1 | w_lane2;
    assign w_is_exc = w_lane1 ? cp0_intexp_1 : cp0_intexp_2;
    assign w_accept = w_idle & w_ev;

    // Only a lane-1 event kills lane 2; a lone lane-2 event lets lane 1 commit.
    assign mem2_clr = w_idle & w_lane1;

    assign flush_pipe       = r_flush;
    assign stall_pc         = r_stall;
    assign redirect_valid   = r_valid;
    assign redirect_pc      = r_pc;
    assign redirect_is_eret = r_is_eret;

    // Main sequencer: IDLE -> FLUSH (FLUSH_CYCLES cycles) -> REDIRECT -> IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_fcnt    <= 4'd0;
            r_flush   <= 1'b0;
            r_stall   <= 1'b0;
            r_valid   <= 1'b0;
            r_pc      <= 32'd0;
            r_is_eret <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ev) begin
                        r_state   <= S_FLUSH;
                        r_fcnt    <= 4'd0;
                        r_flush   <= 1'b1;
                        r_stall   <= 1'b1;
                        r_is_eret <= ~w_is_exc;
                    end
                end
                S_FLUSH: begin
                    if (r_fcnt == FCNT_LAST) begin
                        // EPC_o lags EPC by a cycle, so it is sampled as late as possible.
                        r_state <= S_REDIRECT;
                        r_fcnt  <= 4'd0;
                        r_flush <= 1'b0;
                        r_valid <= 1'b1;
                        r_pc    <= r_is_eret ? epc_i : EXC_VECTOR;
                    end else begin
                        r_fcnt <= r_fcnt + 4'd1;
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready) begin
                        r_state   <= S_IDLE;
                        r_valid   <= 1'b0;
                        r_stall   <= 1'b0;
                        r_is_eret <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_fcnt  <= 4'd0;
                    r_flush <= 1'b0;
                    r_stall <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef EXC_REDIRECT_STAT_EN
    logic [31:0] r_exc_count;
    logic [31:0] r_eret_count;

    assign exc_count  = r_exc_count;
    assign eret_count = r_eret_count;

    // Count accepted events by kind; both counters wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exc_count  <= 32'd0;
            r_eret_count <= 32'd0;
        end else if (w_accept) begin
            if (w_is_exc) begin
                r_exc_count <= r_exc_count + 32'd1;
            end else begin
                r_eret_count <= r_eret_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_exc_redirect.sv
// tb_exc_redirect: directed scenarios plus randomized run checked against a
// cycle-age reference model of the exc_redirect controller.
module tb_exc_redirect;

    localparam int          FC  = 2;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk;
    logic        reset;
    logic        cp0_intexp_1;
    logic        cp0_intexp_2;
    logic        cp0_cln_1;
    logic        cp0_cln_2;
    logic [31:0] epc_i;
    logic        redirect_ready;
    logic        mem2_clr;
    logic        flush_pipe;
    logic        stall_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_is_eret;
`ifdef EXC_REDIRECT_STAT_EN
    logic [31:0] exc_count;
    logic [31:0] eret_count;
`endif

    logic [4:0]  obs;
    assign obs = {mem2_clr, flush_pipe, stall_pc, redirect_valid, redirect_is_eret};

    int total = 0;
    int bad   = 0;

    exc_redirect #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk              (clk),
        .reset            (reset),
        .cp0_intexp_1     (cp0_intexp_1),
        .cp0_intexp_2     (cp0_intexp_2),
        .cp0_cln_1        (cp0_cln_1),
        .cp0_cln_2        (cp0_cln_2),
        .epc_i            (epc_i),
        .redirect_ready   (redirect_ready),
        .mem2_clr         (mem2_clr),
        .flush_pipe       (flush_pipe),
        .stall_pc         (stall_pc),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_is_eret (redirect_is_eret)
`ifdef EXC_REDIRECT_STAT_EN
        ,
        .exc_count        (exc_count),
        .eret_count       (eret_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        cp0_intexp_1   = 1'b0;
        cp0_intexp_2   = 1'b0;
        cp0_cln_1      = 1'b0;
        cp0_cln_2      = 1'b0;
        redirect_ready = 1'b0;
        epc_i          = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        total++;
        if (obs !== 5'b00000) begin bad++; $display("FAIL reset_outputs obs=%b exp=%b", obs, 5'b00000); end
        total++;
        if (redirect_pc !== 32'd0) begin bad++; $display("FAIL reset_pc obs=%h exp=%h", redirect_pc, 32'd0); end
`ifdef EXC_REDIRECT_STAT_EN
        total++;
        if (exc_count !== 32'd0 || eret_count !== 32'd0) begin
            bad++; $display("FAIL reset_counters exc=%0d eret=%0d exp=0/0", exc_count, eret_count);
        end
`endif
        // Strobes while reset is held: state stays IDLE, only mem2_clr reacts.
        @(posedge clk); #1;
        cp0_cln_1 = 1'b1; cp0_intexp_1 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (obs !== 5'b10000) begin bad++; $display("FAIL reset_hold c%0d obs=%b exp=%b", c, obs, 5'b10000); end
            @(posedge clk); #1;
        end
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_lane1_exc();
        logic [4:0] exp_v [5];
        exp_v = '{5'b10000, 5'b01100, 5'b01100, 5'b00110, 5'b00000};
        do_reset();
        redirect_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cp0_cln_1    = (c == 0);
            cp0_intexp_1 = (c == 0);
            @(negedge clk);
            total++;
            if (obs !== exp_v[c]) begin bad++; $display("FAIL lane1_exc c%0d obs=%b exp=%b", c, obs, exp_v[c]); end
            if (c == 3) begin
                total++;
                if (redirect_pc !== VEC) begin bad++; $display("FAIL lane1_exc_pc obs=%h exp=%h", redirect_pc, VEC); end
            end
            @(posedge clk); #1;
        end
`ifdef EXC_REDIRECT_STAT_EN
        total++;
        if (exc_count !== 32'd1 || eret_count !== 32'd0) begin
            bad++; $display("FAIL lane1_exc_counters exc=%0d eret=%0d exp=1/0", exc_count, eret_count);
        end
`endif
        idle_inputs();
    endtask

    task automatic test_lane2_eret();
        logic [4:0] exp_v [5];
        exp_v = '{5'b00000, 5'b01101, 5'b01101, 5'b00111, 5'b00000};
        do_reset();
        redirect_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cp0_cln_2 = (c == 0);
            epc_i     = (c == 0) ? 32'h0 : 32'h8000_1234;
            @(negedge clk);
            total++;
            if (obs !== exp_v[c]) begin bad++; $display("FAIL lane2_eret c%0d obs=%b exp=%b", c, obs, exp_v[c]); end
            if (c == 3) begin
                total++;
                if (redirect_pc !== 32'h8000_1234) begin bad++; $display("FAIL lane2_eret_pc obs=%h exp=%h", redirect_pc, 32'h8000_1234); end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        logic [4:0] exp_v [5];
        exp_v = '{5'b10000, 5'b01101, 5'b01101, 5'b00111, 5'b00000};
        do_reset();
        redirect_ready = 1'b1;
        epc_i          = 32'h1234_5678;
        for (int c = 0; c < 5; c++) begin
            cp0_cln_1    = (c == 0);
            cp0_cln_2    = (c == 0);
            cp0_intexp_2 = (c == 0);
            @(negedge clk);
            total++;
            if (obs !== exp_v[c]) begin bad++; $display("FAIL simultaneous c%0d obs=%b exp=%b", c, obs, exp_v[c]); end
            if (c == 3) begin
                total++;
                if (redirect_pc !== 32'h1234_5678) begin bad++; $display("FAIL simultaneous_pc obs=%h exp=%h", redirect_pc, 32'h1234_5678); end
            end
            @(posedge clk); #1;
        end
`ifdef EXC_REDIRECT_STAT_EN
        total++;
        if (exc_count !== 32'd0 || eret_count !== 32'd1) begin
            bad++; $display("FAIL simultaneous_counters exc=%0d eret=%0d exp=0/1", exc_count, eret_count);
        end
`endif
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_v [11];
        exp_v = '{5'b10000, 5'b01100, 5'b01100, 5'b00110, 5'b00110, 5'b00110,
                  5'b00110, 5'b00110, 5'b00110, 5'b00000, 5'b00000};
        do_reset();
        for (int c = 0; c < 11; c++) begin
            cp0_intexp_1   = (c == 0) || (c == 4) || (c == 5);
            cp0_cln_1      = (c == 0);
            redirect_ready = (c == 8);
            @(negedge clk);
            total++;
            if (obs !== exp_v[c]) begin bad++; $display("FAIL backpressure c%0d obs=%b exp=%b", c, obs, exp_v[c]); end
            if (c >= 3 && c <= 8) begin
                total++;
                if (redirect_pc !== VEC) begin bad++; $display("FAIL backpressure_pc c%0d obs=%h exp=%h", c, redirect_pc, VEC); end
            end
            @(posedge clk); #1;
        end
`ifdef EXC_REDIRECT_STAT_EN
        total++;
        if (exc_count !== 32'd1) begin bad++; $display("FAIL backpressure_count obs=%0d exp=1", exc_count); end
`endif
        idle_inputs();
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        redirect_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            cp0_cln_1    = (c == 0);
            cp0_intexp_1 = (c == 0);
            reset        = (c == 1);
            @(negedge clk);
            total++;
            if (c == 0) begin
                if (obs !== 5'b10000) begin bad++; $display("FAIL reset_mid_flush c%0d obs=%b exp=%b", c, obs, 5'b10000); end
            end else if (c == 1) begin
                if (obs !== 5'b01100) begin bad++; $display("FAIL reset_mid_flush c%0d obs=%b exp=%b", c, obs, 5'b01100); end
            end else begin
                if (obs !== 5'b00000 || redirect_pc !== 32'd0) begin
                    bad++; $display("FAIL reset_mid_flush c%0d obs=%b pc=%h exp=00000/0", c, obs, redirect_pc);
                end
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_v [4];
        exp_v = '{5'b10000, 5'b01100, 5'b01100, 5'b00110};
        do_reset();
        redirect_ready = 1'b1;
        cp0_cln_1      = 1'b1;
        cp0_intexp_1   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_v[c % 4]) begin bad++; $display("FAIL back_to_back c%0d obs=%b exp=%b", c, obs, exp_v[c % 4]); end
            @(posedge clk); #1;
        end
`ifdef EXC_REDIRECT_STAT_EN
        // Accepted at c0, c4, c8.
        total++;
        if (exc_count !== 32'd3) begin bad++; $display("FAIL back_to_back_count obs=%0d exp=3", exc_count); end
`endif
        idle_inputs();
        do_reset();
    endtask

    // Reference model: an accepted event has an age counted in cycles; the
    // flush window is ages 1..FC, the redirect is offered from age FC+1 until
    // the first cycle with ready, and the target is captured at age FC.
    task automatic test_random();
        bit          m_busy;
        int          m_age;
        bit          m_eret;
        logic [31:0] m_target;
        logic [4:0]  e_vec;
        bit          l1;
        bit          l2;
        int          errs;
`ifdef EXC_REDIRECT_STAT_EN
        logic [31:0] m_exc;
        logic [31:0] m_eretc;
        m_exc   = 32'd0;
        m_eretc = 32'd0;
`endif
        do_reset();
        m_busy   = 1'b0;
        m_age    = 0;
        m_eret   = 1'b0;
        m_target = 32'd0;
        errs     = 0;
        for (int c = 0; c < 800; c++) begin
            cp0_cln_1      = ($urandom_range(0, 5) == 0);
            cp0_intexp_1   = ($urandom_range(0, 5) == 0);
            cp0_cln_2      = ($urandom_range(0, 4) == 0);
            cp0_intexp_2   = ($urandom_range(0, 4) == 0);
            redirect_ready = ($urandom_range(0, 2) != 0);
            epc_i          = $urandom;
            reset          = ($urandom_range(0, 79) == 0);
            l1 = cp0_cln_1 | cp0_intexp_1;
            l2 = cp0_cln_2 | cp0_intexp_2;
            e_vec = {!m_busy && l1,
                     m_busy && m_age >= 1 && m_age <= FC,
                     m_busy,
                     m_busy && m_age > FC,
                     m_busy && m_eret};
            @(negedge clk);
            total++;
            if (obs !== e_vec) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL random_outputs c%0d obs=%b exp=%b", c, obs, e_vec);
            end
            if (m_busy && m_age > FC) begin
                total++;
                if (redirect_pc !== m_target) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL random_pc c%0d obs=%h exp=%h", c, redirect_pc, m_target);
                end
            end
`ifdef EXC_REDIRECT_STAT_EN
            total++;
            if (exc_count !== m_exc || eret_count !== m_eretc) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL random_counters c%0d exc=%0d/%0d eret=%0d/%0d", c, exc_count, m_exc, eret_count, m_eretc);
            end
`endif
            // Model update for the coming edge.
            if (reset) begin
                m_busy = 1'b0;
                m_age  = 0;
                m_eret = 1'b0;
`ifdef EXC_REDIRECT_STAT_EN
                m_exc   = 32'd0;
                m_eretc = 32'd0;
`endif
            end else if (!m_busy) begin
                if (l1 || l2) begin
                    m_busy = 1'b1;
                    m_age  = 1;
                    m_eret = l1 ? !cp0_intexp_1 : !cp0_intexp_2;
`ifdef EXC_REDIRECT_STAT_EN
                    if (m_eret) m_eretc = m_eretc + 32'd1;
                    else        m_exc   = m_exc + 32'd1;
`endif
                end
            end else begin
                if (m_age == FC) m_target = m_eret ? epc_i : VEC;
                if (m_age > FC && redirect_ready) m_busy = 1'b0;
                else m_age++;
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_lane1_exc();
        test_lane2_eret();
        test_simultaneous();
        test_backpressure();
        test_reset_mid_flush();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
